gpio_cmd_master: RTL

GPIO_CMD_MASTER -- requirements
Module: gpio_cmd_master

---
 rtl/gpio_cmd_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master
//
// Turns upstream commands into GPIO strobes for the control block. Each
// legal command loads opcode/payload onto o_GPIOctrl/o_GPIOdata, waits one
// setup cycle, then drives o_GPIOvalid high for VALID_HI cycles and low for
// VALID_LO cycles. A data request (op 3) samples i_MCUdata RESP_LAT cycles
// after the strobe rises. A go-to-run (op 4) then parks the block until the
// datapath reports end-of-process.
//
// Ports
//   i_CLK          clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_cmd_valid    upstream command present
//   i_cmd_op       opcode: 0 kernel, 1 image size, 2 image pixel,
//                  3 data request, 4 go-to-run, 5..7 illegal
//   i_cmd_data     command payload
//   o_cmd_ready    block can take a command (IDLE only)
//   o_GPIOdata     payload toward the control block
//   o_GPIOctrl     opcode toward the control block
//   o_GPIOvalid    strobe the control block edge-detects
//   i_MCUdata      processed data returned by the datapath
//   i_EOP          end-of-process from the datapath
//   o_resp_data    captured read word
//   o_resp_valid   one-cycle pulse qualifying o_resp_data
//   o_run_active   high while waiting for i_EOP after go-to-run
//   o_cmd_err      one-cycle pulse when a command is rejected

module gpio_cmd_master #(
  parameter int VALID_HI = 2,
  parameter int VALID_LO = 2,
  parameter int RESP_LAT = 3
) (
  input  logic        i_CLK,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [2:0]  i_cmd_op,
  input  logic [23:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic [23:0] o_GPIOdata,
  output logic [2:0]  o_GPIOctrl,
  output logic        o_GPIOvalid,
  input  logic [12:0] i_MCUdata,
  input  logic        i_EOP,
  output logic [12:0] o_resp_data,
  output logic        o_resp_valid,
  output logic        o_run_active,
  output logic        o_cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE_HI,
    PULSE_LO,
    WAIT_EOP
  } state_t;

  // rise_cnt numbers the strobe cycles: 1 on the first high cycle, up to
  // VALID_HI+VALID_LO on the last low cycle. Both pulse phases and the read
  // sample point are decoded from it.
  localparam logic [4:0] HI_END  = 5'(VALID_HI);
  localparam logic [4:0] LO_END  = 5'(VALID_HI + VALID_LO);
  localparam logic [4:0] RESP_AT = 5'(RESP_LAT);
  localparam logic [2:0] OP_READ = 3'd3;
  localparam logic [2:0] OP_RUN  = 3'd4;

  state_t      state;
  state_t      state_next;
  logic        ready_en;
  logic        eop_seen;
  logic [4:0]  rise_cnt;
  logic        accept;
  logic        op_rejected;
  logic        start_cmd;
  logic        resp_sample;

  assign accept      = i_cmd_valid && o_cmd_ready;
  // A read is only meaningful once the datapath has finished a run.
  assign op_rejected = (i_cmd_op > OP_RUN) || ((i_cmd_op == OP_READ) && !eop_seen);
  assign start_cmd   = accept && !op_rejected;
  // o_GPIOctrl only ever holds an accepted legal opcode, so a 3 there during
  // the strobe means a legal read is in flight.
  assign resp_sample = ((state == PULSE_HI) || (state == PULSE_LO)) &&
                       (o_GPIOctrl == OP_READ) && (rise_cnt == RESP_AT);

  // State register
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; rejected commands are accepted but never leave IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (start_cmd) state_next = SETUP;
      SETUP:    state_next = PULSE_HI;
      PULSE_HI: if (rise_cnt == HI_END) state_next = PULSE_LO;
      PULSE_LO: begin
        if (rise_cnt == LO_END) begin
          state_next = (o_GPIOctrl == OP_RUN) ? WAIT_EOP : IDLE;
        end
      end
      WAIT_EOP: if (i_EOP) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State-decoded outputs. ready_en keeps o_cmd_ready low through reset and
  // lets it rise on the first edge after release.
  always_comb begin
    o_cmd_ready  = 1'b0;
    o_GPIOvalid  = 1'b0;
    o_run_active = 1'b0;
    unique case (state)
      IDLE:     o_cmd_ready  = ready_en;
      PULSE_HI: o_GPIOvalid  = 1'b1;
      WAIT_EOP: o_run_active = 1'b1;
      default:  ;
    endcase
  end

  // Registered datapath: GPIO bus, read capture, flags and strobe counter
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      ready_en     <= 1'b0;
      eop_seen     <= 1'b0;
      rise_cnt     <= 5'd0;
      o_GPIOctrl   <= 3'd0;
      o_GPIOdata   <= 24'd0;
      o_resp_data  <= 13'd0;
      o_resp_valid <= 1'b0;
      o_cmd_err    <= 1'b0;
    end else begin
      ready_en     <= 1'b1;
      eop_seen     <= i_EOP || (eop_seen && !(start_cmd && (i_cmd_op == OP_RUN)));
      o_cmd_err    <= accept && op_rejected;
      o_resp_valid <= resp_sample;
      if (resp_sample) begin
        o_resp_data <= i_MCUdata;
      end
      if (start_cmd) begin
        o_GPIOctrl <= i_cmd_op;
        o_GPIOdata <= i_cmd_data;
      end
      unique case (state)
        SETUP:              rise_cnt <= 5'd1;
        PULSE_HI, PULSE_LO: rise_cnt <= rise_cnt + 5'd1;
        default:            rise_cnt <= 5'd0;
      endcase
    end
  end

endmodule
